mem_port_arbiter: RTL and testbench

- Shares one single-port synchronous program/data memory between three requesters: the boot loader, the data load/store port and the instruction fetch port.
- During boot, only the loader is served. It writes the hex words parsed from the program image.
- After the loader signals completion, the block arbitrates between data and fetch:
  - fixed priority to data;
  - a starvation guard promotes fetch.
- Sits between the memory module and the core/loader.

---
 rtl/mem_port_arbiter.sv | 97 +++++++++
 tb/tb_mem_port_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous memory between the boot loader, the data port and fetch.
// Loader owns the memory until ld_done; afterwards data wins, except that a starved fetch is promoted.
//
// state | meaning
// BOOT  | only loader writes are served, data and fetch are held off
// RUN   | data/fetch arbitration with starvation guard, loader ignored
module mem_port_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int STARVE_LIM = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  input  logic              ld_done,
  output logic              ld_gnt,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              booting
);

  typedef enum logic {BOOT, RUN} state_t;

  localparam logic [3:0] LIM = 4'(STARVE_LIM);

  state_t     state;
  logic [3:0] starve_cnt;
  logic       in_boot;
  logic       in_run;
  logic       promote;

  // Gating with nRST keeps every strobe low while reset is held, whatever the state register holds.
  assign in_boot = nRST && (state == BOOT);
  assign in_run  = nRST && (state == RUN);
  assign promote = in_run && f_req && (starve_cnt == LIM);

  assign ld_gnt  = in_boot & ld_req;
  assign d_gnt   = in_run & d_req & ~promote;
  assign f_gnt   = in_run & f_req & (promote | ~d_req);
  assign mem_en  = ld_gnt | d_gnt | f_gnt;
  assign mem_we  = in_boot | (d_gnt & d_we);
  assign booting = ~nRST | (state == BOOT);
  assign d_rdata = mem_rdata;
  assign f_rdata = mem_rdata;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    if (in_boot) begin
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
    end else if (d_gnt) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (f_gnt) begin
      mem_addr  = f_addr;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state      <= BOOT;
      starve_cnt <= '0;
      d_rvalid   <= 1'b0;
      f_rvalid   <= 1'b0;
    end else begin
      if ((state == BOOT) && ld_done) begin
        state <= RUN;
      end
      d_rvalid <= d_gnt & ~d_we;
      f_rvalid <= f_gnt;
      if (f_gnt) begin
        starve_cnt <= '0;
      end else if (in_run && f_req && (starve_cnt != LIM)) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a reference model predicts grants and read data,
// a separate monitor matches returned rvalid/rdata against the queued expectations.
module tb_mem_port_arbiter;

  localparam int LIM = 4;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ld_req, ld_done, ld_gnt;
  logic [15:0] ld_addr;
  logic [31:0] ld_wdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [15:0] d_addr;
  logic [31:0] d_wdata, d_rdata;
  logic        f_req, f_gnt, f_rvalid;
  logic [15:0] f_addr;
  logic [31:0] f_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        booting;

  always #5 CLK = ~CLK;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .STARVE_LIM(LIM)) dut (
    .CLK(CLK), .nRST(nRST),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_done(ld_done), .ld_gnt(ld_gnt),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .booting(booting)
  );

  // Memory the DUT talks to.
  logic [31:0] mem [0:255];
  always @(posedge CLK) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[7:0]];
    end
  end

  // Reference model state.
  logic [31:0] ref_mem [0:255];
  bit          m_boot = 1'b1;
  int          m_denied = 0;
  typedef struct { int due; logic [31:0] data; } rd_t;
  rd_t d_q[$];
  rd_t f_q[$];

  int  n_checks = 0;
  int  n_pass = 0;
  int  cyc = 0;
  bit  mon_en = 1'b0;
  logic g_ld, g_d, g_f;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // One clock cycle: inputs already applied at the preceding negedge.
  task automatic step();
    logic e_ld, e_d, e_f, e_we;
    logic [15:0] e_a;
    logic [31:0] e_wd;
    #1;
    e_ld = 0; e_d = 0; e_f = 0; e_we = 0; e_a = '0; e_wd = '0;
    if (nRST) begin
      if (m_boot) begin
        e_ld = ld_req; e_we = 1; e_a = ld_addr; e_wd = ld_wdata;
      end else begin
        e_d = d_req && !(f_req && m_denied >= LIM);
        e_f = f_req && !e_d;
        e_we = e_d && d_we;
        if (e_d) begin e_a = d_addr; e_wd = d_wdata; end
        else if (e_f) e_a = f_addr;
      end
    end
    chk("ld_gnt", ld_gnt, e_ld);
    chk("d_gnt", d_gnt, e_d);
    chk("f_gnt", f_gnt, e_f);
    chk("mem_en", mem_en, e_ld | e_d | e_f);
    chk("mem_we", mem_we, e_we);
    chk("booting", booting, !nRST || m_boot);
    if (nRST) begin
      chk("mem_addr", mem_addr, e_a);
      chk("mem_wdata", mem_wdata, e_wd);
    end
    g_ld = ld_gnt; g_d = d_gnt; g_f = f_gnt;
    if (e_d && !d_we) d_q.push_back('{cyc + 1, ref_mem[d_addr[7:0]]});
    if (e_f)          f_q.push_back('{cyc + 1, ref_mem[f_addr[7:0]]});
    @(posedge CLK);
    if (!nRST) begin
      m_boot = 1; m_denied = 0;
      d_q.delete(); f_q.delete();
    end else begin
      if (e_ld) ref_mem[ld_addr[7:0]] = ld_wdata;
      if (e_d && d_we) ref_mem[d_addr[7:0]] = d_wdata;
      if (e_f) m_denied = 0;
      else if (!m_boot && f_req && m_denied < LIM) m_denied++;
      if (m_boot && ld_done) m_boot = 0;
    end
    cyc++;
    @(negedge CLK);
  endtask

  // Monitor: every returned read must match the oldest expectation due this cycle.
  initial begin
    forever begin
      @(negedge CLK);
      if (mon_en) begin
        if (d_q.size() > 0 && d_q[0].due == cyc) begin
          chk("d_rvalid", d_rvalid, 1);
          chk("d_rdata", d_rdata, d_q[0].data);
          void'(d_q.pop_front());
        end else chk("d_rvalid_idle", d_rvalid, 0);
        if (f_q.size() > 0 && f_q[0].due == cyc) begin
          chk("f_rvalid", f_rvalid, 1);
          chk("f_rdata", f_rdata, f_q[0].data);
          void'(f_q.pop_front());
        end else chk("f_rvalid_idle", f_rvalid, 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  logic [14:0] f_pattern;

  initial begin
    for (int i = 0; i < 256; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    mem[8'h10] = 32'hDEADBEEF; ref_mem[8'h10] = 32'hDEADBEEF;
    nRST = 0; ld_req = 1; ld_addr = 0; ld_wdata = 0; ld_done = 0;
    d_req = 1; d_we = 0; d_addr = 16'h5; d_wdata = 0; f_req = 1; f_addr = 16'h6;
    step(); step();
    mon_en = 1;

    // Boot writes with data/fetch knocking.
    nRST = 1;
    for (int i = 0; i < 4; i++) begin
      ld_req = 1; ld_addr = 16'(i); ld_wdata = 32'hA0 + 32'(i);
      step();
    end
    ld_addr = 16'h4; ld_wdata = 32'hA4; ld_done = 1;
    step();
    ld_done = 0; ld_req = 1; ld_addr = 16'h7; d_req = 0; f_req = 1; f_addr = 16'h10;
    step();
    chk("boot_write_4", mem[4], 32'hA4);

    // Starvation guard with both ports saturating.
    ld_req = 0; d_req = 1; d_we = 0; f_req = 1; f_addr = 16'h2;
    for (int i = 0; i < 15; i++) begin
      d_addr = 16'($urandom_range(0, 4));
      step();
      f_pattern[i] = g_f;
    end
    chk("starve_pattern", f_pattern, 15'h4210);

    // Store then load back.
    f_req = 0; d_req = 1; d_we = 1; d_addr = 16'h20; d_wdata = 32'h1234;
    step();
    d_we = 0; d_wdata = 0;
    step();
    d_req = 0;
    step();

    // Randomized traffic honouring the hold-until-grant protocol.
    for (int i = 0; i < 400; i++) begin
      nRST = ($urandom_range(0, 99) != 0);
      ld_done = ($urandom_range(0, 15) == 0);
      if (!ld_req || g_ld) begin
        ld_req = ($urandom_range(0, 3) == 0);
        ld_addr = 16'($urandom_range(0, 63)); ld_wdata = $urandom;
      end
      if (!d_req || g_d) begin
        d_req = ($urandom_range(0, 2) != 0); d_we = 1'($urandom_range(0, 1));
        d_addr = 16'($urandom_range(0, 63)); d_wdata = $urandom;
      end
      if (!f_req || g_f) begin
        f_req = ($urandom_range(0, 1) != 0); f_addr = 16'($urandom_range(0, 63));
      end
      step();
    end

    // Reset in the middle of a read, then BOOT serves only the loader.
    nRST = 0; ld_req = 0; d_req = 0; f_req = 0;
    step();
    nRST = 1; ld_done = 1;
    step();
    ld_done = 0; f_req = 1; f_addr = 16'h10;
    step();
    nRST = 0; ld_req = 1; ld_addr = 16'h30; ld_wdata = 32'hBEEF; d_req = 1; f_req = 1;
    step();
    step();
    chk("rst_f_rvalid", f_rvalid, 0);
    chk("rst_booting", booting, 1);
    nRST = 1;
    step();
    ld_req = 0; d_req = 0; f_req = 0;
    step(); step(); step();
    chk("d_q_drained", d_q.size(), 0);
    chk("f_q_drained", f_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
